btb_assoc: RTL and testbench
============================

BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 The module SHALL have parameter SETS, default 64, giving the number of sets; it SHALL be a power of two, range 4..1024.
REQ-002 The module SHALL have parameter WAYS, default 2, giving the associativity; it SHALL be a power of two, range 1..8.
REQ-003 The module SHALL derive IDX = log2(SETS); set index = pc[IDX+1:2]; tag = pc[31:IDX+2].
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port lookup_pc, input, 32 bits: fetch-stage PC to predict.
REQ-007 Port pred_hit, output, 1 bit: a valid entry matches lookup_pc.
REQ-008 Port pred_taken, output, 1 bit: predict taken (hit and counter MSB = 1).
REQ-009 Port pred_target, output, 32 bits: predicted target when pred_hit is 1, else 0.
REQ-010 Port upd_valid, input, 1 bit: a resolved branch is presented this cycle.
REQ-011 Port upd_pc, input, 32 bits: PC of the resolved branch.
REQ-012 Port upd_taken, input, 1 bit: the resolved outcome.
REQ-013 Port upd_target, input, 32 bits: the resolved target address.

Function
REQ-014 Each entry SHALL hold: valid, tag, 32-bit target, and a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-015 Each set SHALL hold a round-robin victim pointer of log2(WAYS) bits; the pointer SHALL be 0 width when WAYS = 1, with victim = way 0.
REQ-016 Lookup SHALL be combinational from registered state, with zero latency.
REQ-017 On multiple tag matches in a set, the lowest-numbered way SHALL win; allocation rules SHALL prevent duplicates.
REQ-018 pc[1:0] SHALL be ignored for both lookup and update.
REQ-019 Update with upd_valid = 1 and a hit in the upd_pc set: counter +1 if taken (saturating at 11), -1 if not taken (saturating at 00).
REQ-020 Update with upd_valid = 1 and a hit: if taken, target SHALL be overwritten with upd_target; if not taken, target SHALL be unchanged.
REQ-021 Update with upd_valid = 1, a miss, and upd_taken = 1: allocate the lowest invalid way; if none is invalid, allocate the victim-pointer way.
REQ-022 On such an allocation, the new entry SHALL be written as valid = 1, tag, upd_target, counter = 10.
REQ-023 The victim pointer SHALL advance (mod WAYS) only when a valid entry is replaced.
REQ-024 Update with a miss and upd_taken = 0 SHALL leave all state unchanged; no allocation.
REQ-025 upd_valid = 0 SHALL leave all state unchanged.
REQ-026 Lookup and update in the same cycle, any set: lookup SHALL reflect the pre-edge state; there is no bypass.
REQ-027 At most one entry SHALL be written per cycle.

Reset
REQ-028 rst = 1 SHALL immediately clear all valid bits, counters (to 00), and victim pointers (to 0); targets and tags need not be cleared.
REQ-029 While in reset and after it, pred_hit = 0, pred_taken = 0, and pred_target = 0.
REQ-030 rst asserted mid-update SHALL win; the update SHALL be discarded.

Configuration
REQ-031 With macro BTB_FLUSH_EN defined, the module SHALL add input flush (1 bit).
REQ-032 When flush = 1 at a rising edge, all valid bits and victim pointers SHALL clear, and flush SHALL override a same-cycle upd_valid.
REQ-033 Without BTB_FLUSH_EN, the flush port SHALL be absent and the behaviour otherwise identical.

Verification (SETS=64, WAYS=2)
REQ-034 Cold miss: after reset, lookup_pc = 0x100 -> pred_hit = 0, pred_target = 0.
REQ-035 Allocate: update pc 0x100, taken, target 0x400; next cycle lookup 0x100 -> hit = 1, taken = 1 (counter 10), target 0x400; same-cycle lookup -> hit = 0.
REQ-036 Hysteresis: two not-taken updates on 0x100 -> counter 00, hit = 1, taken = 0; one taken update with target 0x480 -> counter 01, taken = 0, target 0x480.
REQ-037 Eviction: taken updates on 0x100, 0x200, 0x300 (all set 0) -> 0x300 replaces way 0 (0x100 misses) and the pointer becomes 1; a fourth taken update 0x100 replaces 0x200.
REQ-038 Not-taken miss: update 0x500, not taken -> lookup 0x500 hit = 0; no other entry changes.
REQ-039 Flush (BTB_FLUSH_EN): populate 4 entries; flush together with upd_valid -> all lookups miss, including the same-cycle update PC.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit saturating direction counters.
// Optional BTB_FLUSH_EN adds a synchronous flush input that invalidates every entry.
module btb_assoc #(
    parameter int SETS = 64,
    parameter int WAYS = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef BTB_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX = $clog2(SETS);
    localparam int TW  = 30 - IDX;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0] valid_q [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [31:0]     tgt_q   [SETS][WAYS];
    logic [1:0]      ctr_q   [SETS][WAYS];

    logic            flush_now;
`ifdef BTB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    logic [IDX-1:0] lk_idx, up_idx;
    logic [TW-1:0]  lk_tag, up_tag;

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[31:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[31:IDX+2];

    // Descending scan so the lowest-numbered matching way is the one left standing.
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = 32'h0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                pred_hit    = 1'b1;
                pred_taken  = ctr_q[lk_idx][w][1];
                pred_target = tgt_q[lk_idx][w];
            end
        end
    end

    logic          up_hit, inv_found;
    logic [WW-1:0] hit_way, inv_way, victim, wr_way;

    always_comb begin
        up_hit    = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit  = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    logic do_upd, alloc, adv;

    assign do_upd = upd_valid && !flush_now;
    assign alloc  = do_upd && !up_hit && upd_taken;
    assign adv    = alloc && !inv_found;
    assign wr_way = up_hit ? hit_way : (inv_found ? inv_way : victim);

    generate
        if (WAYS > 1) begin : g_ptr
            logic [WW-1:0] ptr_q [SETS];

            assign victim = ptr_q[up_idx];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
                end else if (flush_now) begin
                    for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
                end else if (adv) begin
                    ptr_q[up_idx] <= ptr_q[up_idx] + WW'(1);
                end
            end
        end else begin : g_noptr
            assign victim = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= 2'b00;
            end
        end else if (flush_now) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (do_upd) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx][wr_way] != 2'b11)
                        ctr_q[up_idx][wr_way] <= ctr_q[up_idx][wr_way] + 2'b01;
                end else begin
                    if (ctr_q[up_idx][wr_way] != 2'b00)
                        ctr_q[up_idx][wr_way] <= ctr_q[up_idx][wr_way] - 2'b01;
                end
            end else if (alloc) begin
                valid_q[up_idx][wr_way] <= 1'b1;
                ctr_q[up_idx][wr_way]   <= 2'b10;
            end
        end
    end

    // Tags and targets carry no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && do_upd) begin
            if (up_hit) begin
                if (upd_taken) tgt_q[up_idx][wr_way] <= upd_target;
            end else if (alloc) begin
                tag_q[up_idx][wr_way] <= up_tag;
                tgt_q[up_idx][wr_way] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed table-driven bench for btb_assoc (SETS=64, WAYS=2).
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc, upd_target;
`ifdef BTB_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int errors = 0;

    btb_assoc #(.SETS(64), .WAYS(2)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef BTB_FLUSH_EN
        .flush       (flush),
`endif
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] lpc;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic h, input logic t, input logic [31:0] tg);
        chk({nm, ".hit"},    {31'b0, pred_hit},   {31'b0, h});
        chk({nm, ".taken"},  {31'b0, pred_taken}, {31'b0, t});
        chk({nm, ".target"}, pred_target,         tg);
    endtask

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic [31:0] lpc);
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        lookup_pc  = lpc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Each vector: lookup checked against pre-edge state, then the update commits at the edge.
        vq.push_back('{"cold",        1'b0, 32'h000, 1'b0, 32'h000, 32'h100, 1'b0, 1'b0, 32'h000});
        vq.push_back('{"alloc_same",  1'b1, 32'h100, 1'b1, 32'h400, 32'h100, 1'b0, 1'b0, 32'h000});
        vq.push_back('{"alloc_next",  1'b1, 32'h100, 1'b0, 32'hBAD0, 32'h100, 1'b1, 1'b1, 32'h400});
        vq.push_back('{"nt_once",     1'b1, 32'h100, 1'b0, 32'hBAD0, 32'h100, 1'b1, 1'b0, 32'h400});
        vq.push_back('{"nt_twice",    1'b1, 32'h100, 1'b1, 32'h480, 32'h100, 1'b1, 1'b0, 32'h400});
        vq.push_back('{"t_retarget",  1'b1, 32'h500, 1'b0, 32'h999, 32'h103, 1'b1, 1'b0, 32'h480});
        vq.push_back('{"nt_miss",     1'b0, 32'h000, 1'b0, 32'h000, 32'h500, 1'b0, 1'b0, 32'h000});
        vq.push_back('{"unchanged",   1'b1, 32'h200, 1'b1, 32'h600, 32'h100, 1'b1, 1'b0, 32'h480});
        vq.push_back('{"way1_fill",   1'b1, 32'h300, 1'b1, 32'h700, 32'h200, 1'b1, 1'b1, 32'h600});
        vq.push_back('{"evict_w0",    1'b0, 32'h000, 1'b0, 32'h000, 32'h100, 1'b0, 1'b0, 32'h000});
        vq.push_back('{"new_300",     1'b1, 32'h100, 1'b1, 32'h800, 32'h300, 1'b1, 1'b1, 32'h700});
        vq.push_back('{"evict_w1",    1'b0, 32'h000, 1'b0, 32'h000, 32'h200, 1'b0, 1'b0, 32'h000});
        vq.push_back('{"realloc_100", 1'b0, 32'h000, 1'b0, 32'h000, 32'h100, 1'b1, 1'b1, 32'h800});
        vq.push_back('{"keep_300",    1'b1, 32'h104, 1'b1, 32'h900, 32'h300, 1'b1, 1'b1, 32'h700});
        vq.push_back('{"set1_same",   1'b0, 32'h108, 1'b1, 32'hAAA, 32'h104, 1'b1, 1'b1, 32'h900});
        vq.push_back('{"uv0_ignored", 1'b1, 32'h300, 1'b1, 32'h700, 32'h108, 1'b0, 1'b0, 32'h000});
        vq.push_back('{"sat_t2",      1'b1, 32'h300, 1'b1, 32'h700, 32'h300, 1'b1, 1'b1, 32'h700});
        vq.push_back('{"sat_t3",      1'b1, 32'h300, 1'b0, 32'h000, 32'h300, 1'b1, 1'b1, 32'h700});
        vq.push_back('{"sat_nt",      1'b0, 32'h000, 1'b0, 32'h000, 32'h300, 1'b1, 1'b1, 32'h700});

        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; lookup_pc = '0;
`ifdef BTB_FLUSH_EN
        flush = 1'b0;
`endif
        rst = 1'b1;
        #1;
        lookup_pc = 32'h100;
        #1;
        chk_out("in_reset", 1'b0, 1'b0, 32'h0);
        do_reset();

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].uv, vq[i].upc, vq[i].ut, vq[i].utgt, vq[i].lpc);
            #1;
            chk_out(vq[i].name, vq[i].e_hit, vq[i].e_taken, vq[i].e_tgt);
        end

        // Reset asserted mid-cycle with an update pending: outputs drop at once, update is lost.
        @(negedge clk);
        drive(1'b1, 32'h10C, 1'b1, 32'hCCC, 32'h100);
        #1;
        chk_out("pre_rst_hit", 1'b1, 1'b1, 32'h800);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h10C);
        #1;
        chk_out("rst_discard", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        lookup_pc = 32'h300;
        #1;
        chk_out("rst_cleared", 1'b0, 1'b0, 32'h0);

`ifdef BTB_FLUSH_EN
        begin
            logic [31:0] pcs [5];
            pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10C; pcs[4] = 32'h110;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                drive(1'b1, pcs[k], 1'b1, 32'h1000 + 32'(k), 32'h0);
            end
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b0, 32'h0, pcs[2]);
            #1;
            chk_out("fl_populated", 1'b1, 1'b1, 32'h1002);
            @(negedge clk);
            flush = 1'b1;
            drive(1'b1, pcs[4], 1'b1, 32'h2000, 32'h0);
            @(negedge clk);
            flush = 1'b0;
            drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            for (int k = 0; k < 5; k++) begin
                lookup_pc = pcs[k];
                #1;
                chk_out($sformatf("flush_miss%0d", k), 1'b0, 1'b0, 32'h0);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
